// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one RAM bank port between N_REQ requesters (0 = IO loader, then
//   Euler core, then step-size unit). Requesters can hold the port across a
//   multi-beat burst with 'lock'. A watchdog releases a burst whose owner
//   goes quiet. Read returns are tagged back to the requester that issued them.
//
//   Build option: define RAM_ARB_RR_EN for round-robin priority when the
//   port is not locked. Without it, priority is fixed and index 0 is highest.
//
// Ports
//   clk        clock, all logic on posedge
//   rst        synchronous reset, active-low
//   req/we/lock per-requester request valid, write select, hold-grant
//   addr/wdata packed per-requester address / write data (k at [k*W +: W])
//   gnt        one-hot combinational ready
//   rvalid     one-hot read-data-valid for the issuing requester
//   rdata      read data (pass-through of from_ram)
//   from_ram   RAM read data
//   to_ram     registered write data
//   address    registered address
//   WR_RD      registered command: 10 write, 01 read, 00 idle
//   lock_err   one-cycle pulse when the watchdog releases a burst
module ram_port_arbiter #(
  parameter int N_REQ   = 3,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int RD_LAT  = 1,
  parameter int LOCK_TO = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          we,
  input  logic [N_REQ-1:0]          lock,
  input  logic [N_REQ*ADDR_W-1:0]   addr,
  input  logic [N_REQ*DATA_W-1:0]   wdata,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          rvalid,
  output logic [DATA_W-1:0]         rdata,
  input  logic [DATA_W-1:0]         from_ram,
  output logic [DATA_W-1:0]         to_ram,
  output logic [ADDR_W-1:0]         address,
  output logic [1:0]                WR_RD,
  output logic                      lock_err
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(LOCK_TO + 1);

  typedef enum logic [0:0] {IDLE, LOCKED} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   owner, owner_nxt;
  logic [CNT_W-1:0]   idle_cnt, idle_cnt_nxt;
  logic               lock_err_nxt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               xfer;
  logic [IDX_W-1:0]   rr_start;

`ifdef RAM_ARB_RR_EN
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
  assign rr_start = rr_ptr;
`else
  assign rr_start = '0;
`endif

  // Read tag pipeline: stage 0 is aligned with the WR_RD register,
  // stage RD_LAT is aligned with the RAM's from_ram data.
  logic               vld_p [0:RD_LAT];
  logic [IDX_W-1:0]   tag_p [0:RD_LAT];

  // Returns {found, index} of the first requesting index at or after 'start'.
  function automatic logic [IDX_W:0] pick(input logic [N_REQ-1:0] r,
                                          input logic [IDX_W-1:0] start);
    logic             found;
    logic [IDX_W-1:0] idx;
    int               j;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = (int'(start) + i) % N_REQ;
      if (!found && r[j]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] k);
    return (int'(k) == N_REQ - 1) ? '0 : k + 1'b1;
  endfunction

  // Grant: locked owner only, otherwise priority search. Held low in reset.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    xfer    = 1'b0;
    if (rst) begin
      if (state == LOCKED) begin
        gnt_idx = owner;
        xfer    = req[owner];
      end else begin
        {xfer, gnt_idx} = pick(req, rr_start);
      end
      if (xfer) gnt[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    idle_cnt_nxt = idle_cnt;
    lock_err_nxt = 1'b0;
`ifdef RAM_ARB_RR_EN
    rr_ptr_nxt   = rr_ptr;
`endif
    if (state == IDLE) begin
      if (xfer) begin
        idle_cnt_nxt = '0;
`ifdef RAM_ARB_RR_EN
        rr_ptr_nxt   = next_idx(gnt_idx);
`endif
        if (lock[gnt_idx]) begin
          state_nxt = LOCKED;
          owner_nxt = gnt_idx;
        end
      end
    end else begin
      if (xfer) begin
        idle_cnt_nxt = '0;
        if (!lock[owner]) begin
          state_nxt = IDLE;
`ifdef RAM_ARB_RR_EN
          rr_ptr_nxt = next_idx(owner);
`endif
        end
      end else if (idle_cnt == CNT_W'(LOCK_TO - 1)) begin
        // The count reaches LOCK_TO at this edge: force the release now so
        // the pulse and IDLE arbitration coincide in the following cycle.
        state_nxt    = IDLE;
        idle_cnt_nxt = '0;
        lock_err_nxt = 1'b1;
`ifdef RAM_ARB_RR_EN
        rr_ptr_nxt   = next_idx(owner);
`endif
      end else begin
        idle_cnt_nxt = idle_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      owner    <= '0;
      idle_cnt <= '0;
      lock_err <= 1'b0;
`ifdef RAM_ARB_RR_EN
      rr_ptr   <= '0;
`endif
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      idle_cnt <= idle_cnt_nxt;
      lock_err <= lock_err_nxt;
`ifdef RAM_ARB_RR_EN
      rr_ptr   <= rr_ptr_nxt;
`endif
    end
  end

  // Command stage: registered RAM port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      WR_RD   <= 2'b00;
      address <= '0;
      to_ram  <= '0;
    end else if (xfer) begin
      address <= addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
      if (we[gnt_idx]) begin
        to_ram <= wdata[int'(gnt_idx)*DATA_W +: DATA_W];
        WR_RD  <= 2'b10;
      end else begin
        WR_RD  <= 2'b01;
      end
    end else begin
      WR_RD <= 2'b00;
    end
  end

  // Tag stage p0 (with WR_RD) through p(RD_LAT) (with from_ram).
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i <= RD_LAT; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= xfer && !we[gnt_idx];
      for (int i = 1; i <= RD_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_p[0] <= gnt_idx;
    for (int i = 1; i <= RD_LAT; i++) tag_p[i] <= tag_p[i-1];
  end

  always_comb begin
    rvalid = '0;
    if (vld_p[RD_LAT]) rvalid[tag_p[RD_LAT]] = 1'b1;
  end

  assign rdata = from_ram;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   req, we, lock, gnt, rvalid;
  logic [191:0] addr, wdata;
  logic [63:0]  rdata, from_ram, to_ram, address;
  logic [1:0]   WR_RD;
  logic         lock_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .N_REQ(3), .ADDR_W(64), .DATA_W(64), .RD_LAT(2), .LOCK_TO(15)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .from_ram(from_ram), .to_ram(to_ram),
    .address(address), .WR_RD(WR_RD), .lock_err(lock_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int k, input logic [63:0] a);
    addr[k*64 +: 64] = a;
  endtask

  task automatic set_wdata(input int k, input logic [63:0] d);
    wdata[k*64 +: 64] = d;
  endtask

  task automatic do_reset;
    rst = 1'b0; req = '0; we = '0; lock = '0;
    tick;
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; req = 3'b111; we = 3'b111; lock = '0;
    addr = '0; wdata = '0; from_ram = '0;
    tick; tick;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b want 000", gnt); end
    checks++; if (WR_RD !== 2'b00) begin errors++; $display("FAIL reset_wrrd got %b want 00", WR_RD); end
    checks++; if (address !== 64'h0) begin errors++; $display("FAIL reset_addr got %h want 0", address); end
    checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL reset_rvalid got %b want 000", rvalid); end
    rst = 1'b1; req = 3'b011; we = 3'b011;
    set_addr(0, 64'h100); set_wdata(0, 64'h55);
    #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL release_gnt got %b want 001", gnt); end
    tick;
    checks++; if (WR_RD !== 2'b10) begin errors++; $display("FAIL release_wrrd got %b want 10", WR_RD); end
    checks++; if (address !== 64'h100) begin errors++; $display("FAIL release_addr got %h want 100", address); end
    checks++; if (to_ram !== 64'h55) begin errors++; $display("FAIL release_wdata got %h want 55", to_ram); end
    req = '0;
    #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL idle_gnt got %b want 000", gnt); end
    tick;
    checks++; if (WR_RD !== 2'b00) begin errors++; $display("FAIL idle_wrrd got %b want 00", WR_RD); end
    checks++; if (address !== 64'h100) begin errors++; $display("FAIL idle_addr_hold got %h want 100", address); end
  endtask

`ifndef RAM_ARB_RR_EN
  task automatic test_contention;
    do_reset;
    req = 3'b111; we = 3'b111; lock = '0;
    for (int k = 0; k < 3; k++) begin
      set_addr(k, 64'h10 * (k + 1)); set_wdata(k, 64'hA0 + k);
    end
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL fixed_gnt%0d got %b want 001", c, gnt); end
      tick;
      checks++; if (address !== 64'h10 || WR_RD !== 2'b10) begin
        errors++; $display("FAIL fixed_beat%0d got addr %h cmd %b want 10 / 10", c, address, WR_RD); end
    end
    req = 3'b110;
    #1;
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL fixed_drop0 got %b want 010", gnt); end
    tick;
    checks++; if (address !== 64'h20 || to_ram !== 64'hA1) begin
      errors++; $display("FAIL fixed_beat1 got addr %h data %h want 20 / a1", address, to_ram); end
    req = '0;
  endtask
`else
  task automatic test_round_robin;
    logic [2:0]  exp_g [0:3];
    logic [63:0] exp_a [0:3];
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
    exp_a[0] = 64'h10; exp_a[1] = 64'h20; exp_a[2] = 64'h30; exp_a[3] = 64'h10;
    do_reset;
    req = 3'b111; we = 3'b111; lock = '0;
    for (int k = 0; k < 3; k++) set_addr(k, 64'h10 * (k + 1));
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (gnt !== exp_g[c]) begin errors++; $display("FAIL rr_gnt%0d got %b want %b", c, gnt, exp_g[c]); end
      tick;
      checks++; if (address !== exp_a[c]) begin errors++; $display("FAIL rr_addr%0d got %h want %h", c, address, exp_a[c]); end
    end
    req = '0;
  endtask
`endif

  task automatic test_locked_burst;
    logic [63:0] baddr [0:3];
    logic [2:0]  blk   [0:3];
    baddr[0] = 64'd0; baddr[1] = 64'd4; baddr[2] = 64'd8; baddr[3] = 64'd12;
    blk[0] = 3'b010; blk[1] = 3'b010; blk[2] = 3'b010; blk[3] = 3'b000;
    do_reset;
    we = 3'b011; set_addr(0, 64'h77);
    for (int b = 0; b < 4; b++) begin
      req = (b == 0) ? 3'b010 : 3'b011;
      lock = blk[b]; set_addr(1, baddr[b]); set_wdata(1, 64'hB0 + b);
      #1;
      checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL burst_gnt%0d got %b want 010", b, gnt); end
      tick;
      checks++; if (address !== baddr[b] || WR_RD !== 2'b10) begin
        errors++; $display("FAIL burst_beat%0d got addr %h cmd %b want %h / 10", b, address, WR_RD, baddr[b]); end
    end
    req = 3'b001; lock = '0;
    #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL burst_after_gnt got %b want 001", gnt); end
    tick;
    checks++; if (address !== 64'h77) begin errors++; $display("FAIL burst_after_addr got %h want 77", address); end
    req = '0;
  endtask

  task automatic test_watchdog;
    do_reset;
    req = 3'b100; we = 3'b101; lock = 3'b100;
    set_addr(2, 64'h200); set_addr(0, 64'h300);
    #1;
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL wd_first_gnt got %b want 100", gnt); end
    tick;
    req = 3'b001; lock = '0;
    #1;
    for (int c = 1; c <= 15; c++) begin
      checks++; if (gnt !== 3'b000 || lock_err !== 1'b0) begin
        errors++; $display("FAIL wd_stall%0d got gnt %b err %b want 000 / 0", c, gnt, lock_err); end
      tick;
    end
    checks++; if (lock_err !== 1'b1) begin errors++; $display("FAIL wd_pulse got %b want 1", lock_err); end
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL wd_regrant got %b want 001", gnt); end
    tick;
    checks++; if (lock_err !== 1'b0) begin errors++; $display("FAIL wd_pulse_end got %b want 0", lock_err); end
    checks++; if (address !== 64'h300) begin errors++; $display("FAIL wd_addr got %h want 300", address); end
    req = '0;
  endtask

  task automatic test_read_tag;
    do_reset;
    req = 3'b010; we = '0; lock = '0; set_addr(1, 64'd8); set_addr(2, 64'd16);
    #1;
    tick;
    checks++; if (WR_RD !== 2'b01 || address !== 64'd8) begin
      errors++; $display("FAIL rd_cmd got cmd %b addr %h want 01 / 8", WR_RD, address); end
    req = '0;
    tick;
    checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL rd_early got %b want 000", rvalid); end
    from_ram = 64'hDEAD;
    tick;
    checks++; if (rvalid !== 3'b010) begin errors++; $display("FAIL rd_valid got %b want 010", rvalid); end
    checks++; if (rdata !== 64'hDEAD) begin errors++; $display("FAIL rd_data got %h want dead", rdata); end
    tick;
    checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL rd_valid_end got %b want 000", rvalid); end

    // Back-to-back reads from two requesters.
    req = 3'b110;
    #1;
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL rd2_gnt1 got %b want 010", gnt); end
    tick;
    req = 3'b100;
    #1;
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL rd2_gnt2 got %b want 100", gnt); end
    tick;
    req = '0;
    tick;
    checks++; if (rvalid !== 3'b010) begin errors++; $display("FAIL rd2_valid1 got %b want 010", rvalid); end
    tick;
    checks++; if (rvalid !== 3'b100) begin errors++; $display("FAIL rd2_valid2 got %b want 100", rvalid); end

    // Reset between command and return, with a burst held open.
    req = 3'b010; lock = 3'b010;
    #1;
    tick;
    rst = 1'b0; req = 3'b001; lock = '0; set_addr(0, 64'h44);
    tick;
    checks++; if (rvalid !== 3'b000 || WR_RD !== 2'b00) begin
      errors++; $display("FAIL rst_mid got rvalid %b cmd %b want 000 / 00", rvalid, WR_RD); end
    rst = 1'b1;
    #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL rst_lock_drop got %b want 001", gnt); end
    tick;
    checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL rst_no_rvalid got %b want 000", rvalid); end
    req = '0;
    tick;
    checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL rst_no_rvalid2 got %b want 000", rvalid); end
  endtask

  initial begin
    test_reset;
`ifndef RAM_ARB_RR_EN
    test_contention;
`else
    test_round_robin;
`endif
    test_locked_burst;
    test_watchdog;
    test_read_tag;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
